// File: rtl/cpu_trace_formatter_pkg.sv
// Shared definitions for the CPU trace formatter: ASCII character constants,
// FSM and line-segment encodings, and small digit/character helper functions.
package cpu_trace_formatter_pkg;

    localparam logic [7:0] CH_CARET  = 8'h5E;
    localparam logic [7:0] CH_AT     = 8'h40;
    localparam logic [7:0] CH_COLON  = 8'h3A;
    localparam logic [7:0] CH_DOLLAR = 8'h24;
    localparam logic [7:0] CH_STAR   = 8'h2A;
    localparam logic [7:0] CH_LT     = 8'h3C;
    localparam logic [7:0] CH_EQ     = 8'h3D;
    localparam logic [7:0] CH_HASH   = 8'h23;
    localparam logic [7:0] CH_SPACE  = 8'h20;

    localparam logic [13:0] TIME_MAX = 14'd9999;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_EMIT = 2'd2
    } state_t;

    // Line segments, in emission order.
    localparam logic [3:0] SEG_CARET = 4'd0;
    localparam logic [3:0] SEG_TIME  = 4'd1;
    localparam logic [3:0] SEG_AT    = 4'd2;
    localparam logic [3:0] SEG_PC    = 4'd3;
    localparam logic [3:0] SEG_COLON = 4'd4;
    localparam logic [3:0] SEG_SPACE = 4'd5;
    localparam logic [3:0] SEG_TAG   = 4'd6;
    localparam logic [3:0] SEG_ID    = 4'd7;
    localparam logic [3:0] SEG_SEP   = 4'd8;
    localparam logic [3:0] SEG_DATA  = 4'd9;
    localparam logic [3:0] SEG_HASH  = 4'd10;

    // Lowercase hex digit to ASCII.
    function automatic logic [7:0] hex2ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
    endfunction

    // Decimal digit to ASCII.
    function automatic logic [7:0] dec2ascii(input logic [3:0] d);
        return 8'h30 + {4'h0, d};
    endfunction

    // Nibble idx of a 32-bit word counted from the MSB (idx 0 = bits 31:28).
    function automatic logic [3:0] nibble_of(input logic [31:0] w, input logic [2:0] idx);
        return w[{~idx, 2'b00} +: 4];
    endfunction

    // BCD digit at position pos (0 = units).
    function automatic logic [3:0] bcd_digit(input logic [15:0] b, input logic [3:0] pos);
        case (pos)
            4'd0:    return b[3:0];
            4'd1:    return b[7:4];
            4'd2:    return b[11:8];
            default: return b[15:12];
        endcase
    endfunction

    // Number of significant decimal digits, at least one so zero prints "0".
    function automatic logic [3:0] bcd_len(input logic [15:0] b);
        if (b[15:12] != 4'd0)     return 4'd4;
        else if (b[11:8] != 4'd0) return 4'd3;
        else if (b[7:4] != 4'd0)  return 4'd2;
        else                      return 4'd1;
    endfunction

    // Double-dabble correction applied to each BCD digit before a shift.
    function automatic logic [3:0] dabble_adjust(input logic [3:0] d);
        return (d >= 4'd5) ? (d + 4'd3) : d;
    endfunction

endpackage

// File: rtl/cpu_trace_formatter_bin2bcd.sv
// Sequential double-dabble converter: 14-bit binary to 4 BCD digits.
// A start pulse loads the operand; done pulses 14 cycles later and bcd then
// holds its value until the next start.
module trace_bin2bcd
    import cpu_trace_formatter_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [13:0] bin,
    output logic        done,
    output logic [15:0] bcd
);

    logic [13:0] shift_r;
    logic [15:0] bcd_r;
    logic [3:0]  cnt_r;
    logic        busy_r;
    logic        done_r;
    logic [15:0] adj_s;

    // Per-digit add-3 correction ahead of the next shift.
    always_comb begin
        adj_s = 16'd0;
        for (int i = 0; i < 4; i++) begin
            adj_s[i*4 +: 4] = dabble_adjust(bcd_r[i*4 +: 4]);
        end
    end

    // Shift one binary bit into the BCD accumulator per cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_r <= 14'd0;
            bcd_r   <= 16'd0;
            cnt_r   <= 4'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else if (start) begin
            shift_r <= bin;
            bcd_r   <= 16'd0;
            cnt_r   <= 4'd14;
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
        end else if (busy_r) begin
            bcd_r   <= (adj_s << 1) | {15'd0, shift_r[13]};
            shift_r <= shift_r << 1;
            cnt_r   <= cnt_r - 4'd1;
            busy_r  <= (cnt_r != 4'd1);
            done_r  <= (cnt_r == 4'd1);
        end else begin
            done_r  <= 1'b0;
        end
    end

    assign done = done_r;
    assign bcd  = bcd_r;

endmodule

// File: rtl/cpu_trace_formatter.sv
// Serialises one CPU writeback record per handshake into an ASCII trace line,
// one character per accepted cycle:
//   GRF: "^<time>@<pc>: $<grf> <= <data>#"   MEM: "^<time>@<pc>: *<addr> <= <data>#"
module cpu_trace_formatter
    import cpu_trace_formatter_pkg::*;
#(
    parameter int unsigned COLON_SPACES = 1
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_is_mem,
    input  logic [13:0] in_time,
    input  logic [31:0] in_pc,
    input  logic [4:0]  in_grf,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_data,
    output logic [7:0]  char_out,
    output logic        char_valid,
    input  logic        char_ready,
    output logic        drop
);

    localparam logic [3:0] SPACE_LEN = 4'(COLON_SPACES);

    state_t      state_r, state_n;
    logic        in_ready_r, in_ready_n;
    logic [7:0]  char_out_r, char_out_n;
    logic        char_valid_r, char_valid_n;
    logic        drop_r, drop_n;
    logic [3:0]  seg_r, seg_n;
    logic [3:0]  idx_r, idx_n;

    logic        is_mem_r;
    logic [31:0] pc_r, addr_r, data_r;

    logic        accept_s, capture_s, conv_done_s;
    logic        time_done_s, grf_done_s;
    logic [15:0] time_bcd_s, grf_bcd_s;
    logic [3:0]  t_len_s, g_len_s, seg_len_s;
    logic [3:0]  nxt_seg_s, nxt_idx_s;
    logic [7:0]  nxt_char_s;

    assign accept_s    = in_valid & in_ready_r;
    assign conv_done_s = time_done_s & grf_done_s;
    assign t_len_s     = bcd_len(time_bcd_s);
    assign g_len_s     = bcd_len(grf_bcd_s);

    trace_bin2bcd u_time_bcd (
        .clk   (clk),
        .reset (reset),
        .start (capture_s),
        .bin   (in_time),
        .done  (time_done_s),
        .bcd   (time_bcd_s)
    );

    trace_bin2bcd u_grf_bcd (
        .clk   (clk),
        .reset (reset),
        .start (capture_s),
        .bin   ({9'd0, in_grf}),
        .done  (grf_done_s),
        .bcd   (grf_bcd_s)
    );

    // Length of the segment currently being emitted.
    always_comb begin
        seg_len_s = 4'd1;
        case (seg_r)
            SEG_TIME:           seg_len_s = t_len_s;
            SEG_PC, SEG_DATA:   seg_len_s = 4'd8;
            SEG_SPACE:          seg_len_s = SPACE_LEN;
            SEG_ID:             seg_len_s = is_mem_r ? 4'd8 : g_len_s;
            SEG_SEP:            seg_len_s = 4'd4;
            default:            seg_len_s = 4'd1;
        endcase
    end

    // Position of the character following the one on char_out.
    always_comb begin
        nxt_seg_s = seg_r;
        nxt_idx_s = idx_r;
        if (idx_r == seg_len_s - 4'd1) begin
            nxt_seg_s = seg_r + 4'd1;
            nxt_idx_s = 4'd0;
        end else begin
            nxt_idx_s = idx_r + 4'd1;
        end
    end

    // ASCII character at the next position.
    always_comb begin
        nxt_char_s = 8'h00;
        case (nxt_seg_s)
            SEG_CARET: nxt_char_s = CH_CARET;
            SEG_TIME:  nxt_char_s = dec2ascii(bcd_digit(time_bcd_s, t_len_s - 4'd1 - nxt_idx_s));
            SEG_AT:    nxt_char_s = CH_AT;
            SEG_PC:    nxt_char_s = hex2ascii(nibble_of(pc_r, nxt_idx_s[2:0]));
            SEG_COLON: nxt_char_s = CH_COLON;
            SEG_SPACE: nxt_char_s = CH_SPACE;
            SEG_TAG:   nxt_char_s = is_mem_r ? CH_STAR : CH_DOLLAR;
            SEG_ID:    nxt_char_s = is_mem_r
                                    ? hex2ascii(nibble_of(addr_r, nxt_idx_s[2:0]))
                                    : dec2ascii(bcd_digit(grf_bcd_s, g_len_s - 4'd1 - nxt_idx_s));
            SEG_SEP: begin
                case (nxt_idx_s)
                    4'd1:    nxt_char_s = CH_LT;
                    4'd2:    nxt_char_s = CH_EQ;
                    default: nxt_char_s = CH_SPACE;
                endcase
            end
            SEG_DATA:  nxt_char_s = hex2ascii(nibble_of(data_r, nxt_idx_s[2:0]));
            SEG_HASH:  nxt_char_s = CH_HASH;
            default:   nxt_char_s = 8'h00;
        endcase
    end

    // Next-state and next registered-output logic.
    always_comb begin
        state_n      = state_r;
        char_out_n   = char_out_r;
        char_valid_n = char_valid_r;
        drop_n       = 1'b0;
        seg_n        = seg_r;
        idx_n        = idx_r;
        capture_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                char_valid_n = 1'b0;
                if (accept_s) begin
                    if (in_time > TIME_MAX) begin
                        drop_n = 1'b1;
                    end else begin
                        capture_s = 1'b1;
                        state_n   = ST_CONV;
                    end
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_CONV: begin
                if (conv_done_s) begin
                    state_n      = ST_EMIT;
                    char_valid_n = 1'b1;
                    char_out_n   = CH_CARET;
                    seg_n        = SEG_CARET;
                    idx_n        = 4'd0;
                end else begin
                    state_n = ST_CONV;
                end
            end
            ST_EMIT: begin
                if (char_valid_r && char_ready) begin
                    if (seg_r == SEG_HASH) begin
                        state_n      = ST_IDLE;
                        char_valid_n = 1'b0;
                    end else begin
                        seg_n      = nxt_seg_s;
                        idx_n      = nxt_idx_s;
                        char_out_n = nxt_char_s;
                    end
                end else begin
                    state_n = ST_EMIT;
                end
            end
            default: begin
                state_n      = ST_IDLE;
                char_valid_n = 1'b0;
            end
        endcase
        in_ready_n = (state_n == ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            in_ready_r   <= 1'b1;
            char_out_r   <= 8'h00;
            char_valid_r <= 1'b0;
            drop_r       <= 1'b0;
            seg_r        <= SEG_CARET;
            idx_r        <= 4'd0;
        end else begin
            state_r      <= state_n;
            in_ready_r   <= in_ready_n;
            char_out_r   <= char_out_n;
            char_valid_r <= char_valid_n;
            drop_r       <= drop_n;
            seg_r        <= seg_n;
            idx_r        <= idx_n;
        end
    end

    // Record capture; fields stay frozen until the next accepted record.
    always_ff @(posedge clk) begin
        if (reset) begin
            is_mem_r <= 1'b0;
            pc_r     <= 32'd0;
            addr_r   <= 32'd0;
            data_r   <= 32'd0;
        end else if (capture_s) begin
            is_mem_r <= in_is_mem;
            pc_r     <= in_pc;
            addr_r   <= in_addr;
            data_r   <= in_data;
        end else begin
            is_mem_r <= is_mem_r;
            pc_r     <= pc_r;
            addr_r   <= addr_r;
            data_r   <= data_r;
        end
    end

    assign in_ready   = in_ready_r;
    assign char_out   = char_out_r;
    assign char_valid = char_valid_r;
    assign drop       = drop_r;

endmodule
